instruction_decode: RTL and testbench
=====================================

Name: instruction_decode

Overview:
Decode stage directly downstream of instruction fetch. It consumes the IFID instruction word and its PC, reads the 32-entry register file, generates the sign-extended immediate, and registers everything into the ID/EX pipeline register. The IDEX control bus feeds back to fetch for hazard detection and onward to execute. The write-back port writes the register file.

Parameters:
DATA_W, 32, register file and operand data width
CNT_W, 16, width of issued-instruction counter

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  asynchronous reset, active-high
IFID  input  32  instruction from fetch; 32'h00000000 is NOP
IFID_PC  input  8  byte PC of IFID instruction
flush  input  1  squash the instruction being decoded this cycle (taken branch)
wb_en  input  1  register file write enable
wb_rd  input  5  write-back destination register
wb_data  input  DATA_W  write-back data
IDEX  output  40  registered control bus: [6:0] opcode, [11:7] rd, [14:12] funct3, [19:15] rs1, [24:20] rs2, [31:25] funct7, [39:32] PC
IDEX_valid  output  1  registered; 1 = IDEX holds a real instruction
IDEX_rs1_data  output  DATA_W  registered rs1 operand
IDEX_rs2_data  output  DATA_W  registered rs2 operand
IDEX_imm  output  DATA_W  registered sign-extended immediate
issue_count  output  CNT_W  number of valid instructions issued to IDEX

Behaviour:
- Reset (async, rst=1): IDEX=0, IDEX_valid=0, rs1/rs2 data=0, IDEX_imm=0, issue_count=0, all 32 registers=0. Reset mid-operation discards the in-flight instruction immediately.
- Latency: 1 cycle. IFID sampled at posedge N appears on the IDEX outputs after posedge N.
- Recognised opcodes: R 0110011, I 0010011, Lw 0000011, Sw 0100011, B 1100011, J 1101111.
- Bubble: if IFID opcode is unrecognised (including NOP), or flush=1, load IDEX=0, IDEX_valid=0, all data outputs=0. Flush takes priority over every other condition. A bubble must present opcode 0 so that fetch hazard logic never matches it.
- Valid issue: IDEX[31:0]=IFID, IDEX[39:32]=IFID_PC, IDEX_valid=1, issue_count increments by 1. The counter wraps from 2^CNT_W-1 to 0.
- Field masking: for opcodes without rd (Sw, B), IDEX[11:7] is forced to 0 so downstream hazard compares see x0.
- Immediate, sign-extended from instruction bit 31 to DATA_W:
  - I/Lw: ins[31:20]
  - Sw: {ins[31:25], ins[11:7]}
  - B: {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}
  - J: {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}
  - R: 0
- Register file: 32 x DATA_W, 2 combinational read ports, 1 synchronous write port at posedge when wb_en=1.
  - Writes to x0 are ignored; x0 always reads 0.
- Write-through bypass: if wb_en=1, wb_rd!=0, and wb_rd equals rs1 (or rs2) of the instruction being decoded, that operand takes wb_data in the same cycle.
- Operands are read regardless of opcode. For I/Lw, the rs2 field is decoded from raw bits. Execute ignores operands it does not need.
- Simultaneous write-back and flush: the register write still happens; only the IDEX load is squashed.
- No stall input: fetch inserts NOPs for hazards, so this stage loads IDEX every cycle.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> IDEX=0, IDEX_valid=0, issue_count=0 before the next edge; reading x5 afterwards returns 0.
- Write then read: wb_en=1, wb_rd=3, wb_data=0x1234 for one cycle; next cycle IFID=add x1,x3,x0 (0x000180B3) -> IDEX_rs1_data=0x1234, IDEX_rs2_data=0, IDEX[11:7]=1, IDEX_valid=1, issue_count=1.
- Bypass and x0 protection: same cycle wb_en=1, wb_rd=3, wb_data=0xBEEF and IFID=addi x2,x3,-1 (0xFFF18113) -> IDEX_rs1_data=0xBEEF, IDEX_imm=0xFFFFFFFF. Separately, a write of 0x55 to x0 leaves x0 reading 0.
- Immediates: beq x1,x2,-8 (0xFE208CE3) -> IDEX_imm=0xFFFFFFF8, IDEX[11:7]=0. sw x2,12(x1) (0x0020A623) -> IDEX_imm=12. jal x1,+2048 (0x001000EF) -> IDEX_imm=0x800.
- Bubbles: IFID=0x00000000 -> IDEX=0, IDEX_valid=0, counter unchanged. A valid add with flush=1 -> IDEX=0, IDEX_valid=0, counter unchanged. IFID=0x0000007F (illegal opcode) -> bubble.
- Counter wrap: preload issue_count to 0xFFFF via 65535 valid issues, then issue 1 more -> issue_count=0.

Source files
------------

// File: rtl/instruction_decode.sv
// Decode stage: register file read with write-through bypass, immediate generation,
// and the ID/EX pipeline register with an issued-instruction counter.
module instruction_decode #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       IFID,
    input  logic [7:0]        IFID_PC,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [39:0]       IDEX,
    output logic              IDEX_valid,
    output logic [DATA_W-1:0] IDEX_rs1_data,
    output logic [DATA_W-1:0] IDEX_rs2_data,
    output logic [DATA_W-1:0] IDEX_imm,
    output logic [CNT_W-1:0]  issue_count
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_J  = 7'b1101111;

    logic [DATA_W-1:0] r_regs [0:31];

    logic [6:0]        w_opcode;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic              w_known;
    logic              w_has_rd;
    logic              w_issue;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;

    assign w_opcode = IFID[6:0];
    assign w_rs1    = IFID[19:15];
    assign w_rs2    = IFID[24:20];

    always_comb begin
        w_known  = 1'b0;
        w_has_rd = 1'b1;
        w_imm    = '0;
        case (w_opcode)
            OP_R: begin
                w_known = 1'b1;
            end
            OP_I, OP_LW: begin
                w_known = 1'b1;
                w_imm   = {{(DATA_W-12){IFID[31]}}, IFID[31:20]};
            end
            OP_SW: begin
                w_known  = 1'b1;
                w_has_rd = 1'b0;
                w_imm    = {{(DATA_W-12){IFID[31]}}, IFID[31:25], IFID[11:7]};
            end
            OP_B: begin
                w_known  = 1'b1;
                w_has_rd = 1'b0;
                w_imm    = {{(DATA_W-13){IFID[31]}}, IFID[31], IFID[7],
                            IFID[30:25], IFID[11:8], 1'b0};
            end
            OP_J: begin
                w_known = 1'b1;
                w_imm   = {{(DATA_W-21){IFID[31]}}, IFID[31], IFID[19:12],
                           IFID[20], IFID[30:21], 1'b0};
            end
            default: begin
                w_known = 1'b0;
            end
        endcase
    end

    // A write-back landing this cycle is forwarded so the consumer never sees stale data.
    always_comb begin
        if (w_rs1 == 5'd0)
            w_rs1_data = '0;
        else if (wb_en && (wb_rd == w_rs1))
            w_rs1_data = wb_data;
        else
            w_rs1_data = r_regs[w_rs1];

        if (w_rs2 == 5'd0)
            w_rs2_data = '0;
        else if (wb_en && (wb_rd == w_rs2))
            w_rs2_data = wb_data;
        else
            w_rs2_data = r_regs[w_rs2];
    end

    assign w_issue = w_known && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                r_regs[i] <= '0;
        end else if (wb_en && (wb_rd != 5'd0)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // Bubbles load all zeros so the opcode field can never match fetch hazard compares.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IDEX          <= '0;
            IDEX_valid    <= 1'b0;
            IDEX_rs1_data <= '0;
            IDEX_rs2_data <= '0;
            IDEX_imm      <= '0;
            issue_count   <= '0;
        end else if (w_issue) begin
            IDEX          <= {IFID_PC, IFID[31:12], (w_has_rd ? IFID[11:7] : 5'd0), IFID[6:0]};
            IDEX_valid    <= 1'b1;
            IDEX_rs1_data <= w_rs1_data;
            IDEX_rs2_data <= w_rs2_data;
            IDEX_imm      <= w_imm;
            issue_count   <= issue_count + CNT_W'(1);
        end else begin
            IDEX          <= '0;
            IDEX_valid    <= 1'b0;
            IDEX_rs1_data <= '0;
            IDEX_rs2_data <= '0;
            IDEX_imm      <= '0;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Randomized + directed bench for instruction_decode: driver pushes expected ID/EX
// contents from an arithmetic reference model; a monitor pops and compares each cycle.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IFID;
    logic [7:0]  IFID_PC;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [39:0] IDEX;
    logic        IDEX_valid;
    logic [31:0] IDEX_rs1_data;
    logic [31:0] IDEX_rs2_data;
    logic [31:0] IDEX_imm;
    logic [15:0] issue_count;

    instruction_decode #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .IFID(IFID), .IFID_PC(IFID_PC), .flush(flush),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .IDEX(IDEX), .IDEX_valid(IDEX_valid), .IDEX_rs1_data(IDEX_rs1_data),
        .IDEX_rs2_data(IDEX_rs2_data), .IDEX_imm(IDEX_imm), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] idex;
        logic        valid;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] m_regs[32];
    int          m_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // 0 = bubble, 1 = R, 2 = I/Lw, 3 = Sw, 4 = B, 5 = J
    function automatic int kind(input logic [6:0] op);
        case (op)
            7'h33:        return 1;
            7'h13, 7'h03: return 2;
            7'h23:        return 3;
            7'h63:        return 4;
            7'h6F:        return 5;
            default:      return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_imm(input logic [31:0] ins);
        int v;
        int s;
        s = ins[31] ? 1 : 0;
        case (kind(ins[6:0]))
            2:       v = int'(ins[31:20]) - s * 4096;
            3:       v = int'(ins[31:25]) * 32 + int'(ins[11:7]) - s * 4096;
            4:       v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2 - s * 4096;
            5:       v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2 - s * (1 << 20);
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] r, input logic we,
                                               input logic [4:0] rd, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (we && rd == r) return wd;
        return m_regs[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 0;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [7:0] pc, input logic fl,
                         input logic we, input logic [4:0] rd, input logic [31:0] wd);
        exp_t e;
        int   k;
        @(negedge clk);
        IFID = ins; IFID_PC = pc; flush = fl; wb_en = we; wb_rd = rd; wb_data = wd;
        k = kind(ins[6:0]);
        if (fl || k == 0) begin
            e.idex = '0; e.valid = 1'b0; e.rs1 = '0; e.rs2 = '0; e.imm = '0;
        end else begin
            m_cnt   = (m_cnt + 1) % 65536;
            e.idex  = {pc, ins};
            if (k == 3 || k == 4) e.idex[11:7] = 5'd0;
            e.valid = 1'b1;
            e.rs1   = model_read(ins[19:15], we, rd, wd);
            e.rs2   = model_read(ins[24:20], we, rd, wd);
            e.imm   = model_imm(ins);
        end
        e.cnt = 16'(m_cnt);
        exp_q.push_back(e);
        if (we && rd != 5'd0) m_regs[rd] = wd;
    endtask

    task automatic nop();
        drive(32'h0, 8'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic mid_reset();
        nop();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_idex", IDEX, 0);
        chk("rst_valid", IDEX_valid, 0);
        chk("rst_cnt", issue_count, 0);
        chk("rst_imm", IDEX_imm, 0);
        model_reset();
        exp_q.delete();
        #1 rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_ins(input logic force_valid);
        logic [6:0] ops[9];
        logic [6:0] op;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h00, 7'h7F, 7'h00};
        op = force_valid ? ops[$urandom_range(0, 5)] : ops[$urandom_range(0, 8)];
        if (!force_valid && $urandom_range(0, 8) == 0) op = 7'($urandom);
        if (!force_valid && op == 7'h00 && $urandom_range(0, 1) == 1) return 32'h0;
        return {25'($urandom), op};
    endfunction

    task automatic rand_drive(input logic force_valid);
        logic [31:0] ins;
        logic [4:0]  rd;
        ins = rand_ins(force_valid);
        case ($urandom_range(0, 2))
            0:       rd = ins[19:15];
            1:       rd = ins[24:20];
            default: rd = 5'($urandom);
        endcase
        drive(ins, 8'($urandom), force_valid ? 1'b0 : ($urandom_range(0, 9) == 0),
              1'($urandom), rd, $urandom);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("idex", IDEX, mon_e.idex);
            chk("valid", IDEX_valid, mon_e.valid);
            chk("rs1_data", IDEX_rs1_data, mon_e.rs1);
            chk("rs2_data", IDEX_rs2_data, mon_e.rs2);
            chk("imm", IDEX_imm, mon_e.imm);
            chk("issue_count", issue_count, mon_e.cnt);
        end
    end

    initial begin
        rst = 1'b1;
        IFID = '0; IFID_PC = '0; flush = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_idex", IDEX, 0);
        chk("reset_valid", IDEX_valid, 0);
        chk("reset_cnt", issue_count, 0);
        rst = 1'b0;

        drive(32'h0, 8'h0, 1'b0, 1'b1, 5'd3, 32'h1234);
        drive(32'h000180B3, 8'h04, 1'b0, 1'b0, 5'd0, 32'h0);
        settle();
        chk("wr_rd_rs1", IDEX_rs1_data, 32'h1234);
        chk("wr_rd_rd", IDEX[11:7], 5'd1);
        chk("wr_rd_cnt", issue_count, 1);

        drive(32'hFFF18113, 8'h08, 1'b0, 1'b1, 5'd3, 32'hBEEF);
        settle();
        chk("bypass_rs1", IDEX_rs1_data, 32'hBEEF);
        chk("bypass_imm", IDEX_imm, 32'hFFFFFFFF);

        drive(32'h0, 8'h0, 1'b0, 1'b1, 5'd0, 32'h55);
        drive(32'h000000B3, 8'h0C, 1'b0, 1'b0, 5'd0, 32'h0);
        settle();
        chk("x0_read", IDEX_rs1_data, 32'h0);

        drive(32'hFE208CE3, 8'h10, 1'b0, 1'b0, 5'd0, 32'h0);
        settle();
        chk("beq_imm", IDEX_imm, 32'hFFFFFFF8);
        chk("beq_rd", IDEX[11:7], 5'd0);
        drive(32'h0020A623, 8'h14, 1'b0, 1'b0, 5'd0, 32'h0);
        settle();
        chk("sw_imm", IDEX_imm, 32'd12);
        drive(32'h001000EF, 8'h18, 1'b0, 1'b0, 5'd0, 32'h0);
        settle();
        chk("jal_imm", IDEX_imm, 32'h800);

        nop();
        settle();
        chk("nop_valid", IDEX_valid, 0);
        drive(32'h000180B3, 8'h1C, 1'b1, 1'b0, 5'd0, 32'h0);
        settle();
        chk("flush_idex", IDEX, 0);
        drive(32'h0000007F, 8'h20, 1'b0, 1'b0, 5'd0, 32'h0);
        settle();
        chk("illegal_valid", IDEX_valid, 0);

        drive(32'h0, 8'h0, 1'b0, 1'b1, 5'd5, 32'hA5A5);
        mid_reset();
        drive(32'h000280B3, 8'h24, 1'b0, 1'b0, 5'd0, 32'h0);
        settle();
        chk("x5_after_rst", IDEX_rs1_data, 32'h0);

        for (int i = 0; i < 400; i++) rand_drive(1'b0);
        nop();

        mid_reset();
        for (int i = 0; i < 65535; i++) rand_drive(1'b1);
        settle();
        chk("cnt_full", issue_count, 16'hFFFF);
        rand_drive(1'b1);
        settle();
        chk("cnt_wrap", issue_count, 16'h0000);
        nop();
        settle();

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
